inf_stream: RTL

- Parametrised successor to the single-line instruction fetch unit; sits between the I-cache port and the decoder.
- Streams cache lines into a circular byte buffer with configurable line size, buffer depth and decode window.
- Blocks requests on free space, not fixed thresholds; the decode window wraps circularly.
- Redirect while a request is in flight drains the stale response cleanly.

---
 rtl/inf_stream_if.sv | 31 +++
 rtl/inf_stream.sv | 112 +++++++++++
 2 files changed

// File: rtl/inf_stream_if.sv
// Fetch/decode bus for inf_stream: I-cache request/response plus decode window.
// master = fetch unit, slave = surrounding cache/decoder environment.
interface inf_stream_if #(
  parameter int LINE_BYTES = 64,
  parameter int BUF_LINES  = 2,
  parameter int WIN_BYTES  = 15
);
  localparam int CW = $clog2(LINE_BYTES*BUF_LINES) + 1;

  logic                    set_rip;
  logic [63:0]             new_rip;
  logic                    ic_enable;
  logic [63:0]             iaddr;
  logic [LINE_BYTES*8-1:0] idata;
  logic                    ic_done;
  logic [WIN_BYTES*8-1:0]  decode_bytes;
  logic [63:0]             decode_rip;
  logic [7:0]              bytes_decoded;
  logic                    if_dc;
  logic                    dc_if;
  logic [CW-1:0]           buf_count;

  modport master (
    input  set_rip, new_rip, idata, ic_done, bytes_decoded, dc_if,
    output ic_enable, iaddr, decode_bytes, decode_rip, if_dc, buf_count
  );
  modport slave (
    output set_rip, new_rip, idata, ic_done, bytes_decoded, dc_if,
    input  ic_enable, iaddr, decode_bytes, decode_rip, if_dc, buf_count
  );
endinterface

// File: rtl/inf_stream.sv
// Instruction fetch streamer: fills a circular byte buffer with I-cache lines
// and presents a wrapping decode window to the decoder.
module inf_stream #(
  parameter int LINE_BYTES = 64,
  parameter int BUF_LINES  = 2,
  parameter int WIN_BYTES  = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  inf_stream_if.master bus
);
  localparam int BUF_BYTES = LINE_BYTES * BUF_LINES;
  localparam int AW = $clog2(BUF_BYTES);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {UNINIT, IDLE, WAIT, DRAIN} state_t;

  state_t                    state;
  logic [PW-1:0]             wr_ptr, rd_ptr, count, adv;
  logic [SW-1:0]             skip;
  logic [63:0]               fetch_rip;
  logic [BUF_BYTES-1:0][7:0] mem;
  logic [BUF_BYTES-1:0]      wr_en;
  logic [BUF_BYTES-1:0][7:0] wr_data;
  logic                      consume, space_ok, fill;

  assign count         = wr_ptr - rd_ptr;
  assign bus.buf_count = count;
  assign bus.if_dc     = count >= PW'(WIN_BYTES);
  assign consume       = bus.dc_if && bus.if_dc && !bus.set_rip;
  // Oversized consumption is illegal; it is dropped rather than corrupting rd_ptr.
  assign adv      = (bus.bytes_decoded > 8'(WIN_BYTES)) ? '0 : PW'(bus.bytes_decoded);
  assign space_ok = (PW'(BUF_BYTES) - count) >= PW'(LINE_BYTES);
  assign fill     = (state == WAIT) && bus.ic_done && !bus.set_rip;

  // Each buffer byte decides whether it falls in the incoming line's
  // [skip, LINE_BYTES) slice landing at wr_ptr, and which idata byte it takes.
  for (genvar j = 0; j < BUF_BYTES; j++) begin : g_wr
    logic [AW-1:0] off;
    logic [SW-1:0] src;
    assign off        = AW'(j) - wr_ptr[AW-1:0];
    assign src        = SW'(off) + skip;
    assign wr_en[j]   = fill && (({1'b0, off} + (AW+1)'(skip)) < (AW+1)'(LINE_BYTES));
    assign wr_data[j] = bus.idata[{src, 3'b000} +: 8];
  end

  for (genvar k = 0; k < WIN_BYTES; k++) begin : g_win
    logic [AW-1:0] ra;
    assign ra = rd_ptr[AW-1:0] + AW'(k);
    assign bus.decode_bytes[8*k +: 8] = mem[ra];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= UNINIT;
      bus.ic_enable  <= 1'b0;
      bus.iaddr      <= '0;
      bus.decode_rip <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      skip           <= '0;
      fetch_rip      <= '0;
      mem            <= '0;
    end else begin
      for (int j = 0; j < BUF_BYTES; j++)
        if (wr_en[j]) mem[j] <= wr_data[j];
      if (bus.set_rip) begin
        rd_ptr         <= '0;
        wr_ptr         <= '0;
        bus.decode_rip <= bus.new_rip;
        fetch_rip      <= {bus.new_rip[63:SW], {SW{1'b0}}};
        skip           <= bus.new_rip[SW-1:0];
        // An outstanding request must still see its response before reuse.
        if (state == WAIT && !bus.ic_done)
          state <= DRAIN;
        else if (!(state == DRAIN && !bus.ic_done)) begin
          state         <= IDLE;
          bus.ic_enable <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: if (space_ok) begin
            bus.ic_enable <= 1'b1;
            bus.iaddr     <= fetch_rip;
            state         <= WAIT;
          end
          WAIT: if (bus.ic_done) begin
            wr_ptr        <= wr_ptr + PW'(LINE_BYTES) - PW'(skip);
            skip          <= '0;
            fetch_rip     <= fetch_rip + 64'(LINE_BYTES);
            bus.ic_enable <= 1'b0;
            state         <= IDLE;
          end
          DRAIN: if (bus.ic_done) begin
            bus.ic_enable <= 1'b0;
            state         <= IDLE;
          end
          default: ;
        endcase
        if (consume) begin
          rd_ptr         <= rd_ptr + adv;
          bus.decode_rip <= bus.decode_rip + 64'(adv);
        end
      end
    end
  end

  a_bytes_decoded: assert property (@(posedge clk) disable iff (!reset_n)
    consume |-> (bus.bytes_decoded <= 8'(WIN_BYTES)));

endmodule
